// File: rtl/glb_fifo_xfer_engine.sv
// Multi-channel FIFO<->GLB transfer engine: a round-robin arbiter plus a read-return steering pipe.
// Optional XFER_PERF_CNT_EN adds saturating busy/stall cycle counters.
module glb_fifo_xfer_engine #(
  parameter int CH_NUM     = 32,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int GLB_RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_clr_i,
  input  logic                       start_i,
  input  logic [CH_NUM-1:0]          ch_need_i,
  input  logic [CH_NUM-1:0]          ch_dir_i,
  input  logic [CH_NUM*CNT_W-1:0]    ch_num_i,
  input  logic [CH_NUM*ADDR_W-1:0]   ch_base_addr_i,
  input  logic [ADDR_W-1:0]          addr_stride_i,
  input  logic [CH_NUM-1:0]          fifo_full_i,
  input  logic [CH_NUM-1:0]          fifo_empty_i,
  input  logic [CH_NUM*DATA_W-1:0]   fifo_pop_data_i,
  output logic [CH_NUM-1:0]          fifo_push_o,
  output logic [DATA_W-1:0]          fifo_push_data_o,
  output logic [CH_NUM-1:0]          fifo_pop_o,
  output logic                       glb_req_o,
  output logic                       glb_we_o,
  output logic [ADDR_W-1:0]          glb_addr_o,
  output logic [DATA_W-1:0]          glb_wdata_o,
  input  logic                       glb_gnt_i,
  input  logic [DATA_W-1:0]          glb_rdata_i,
  output logic [CH_NUM-1:0]          ch_done_o,
`ifdef XFER_PERF_CNT_EN
  output logic [31:0]                perf_busy_cyc_o,
  output logic [31:0]                perf_stall_cyc_o,
`endif
  output logic                       all_done_o
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CH_NUM-1:0] ONE_HOT0 = {{(CH_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ch_st_e;

  ch_st_e                           st_q [CH_NUM];
  ch_st_e                           st_d [CH_NUM];
  logic [CH_NUM-1:0][CNT_W-1:0]     rem_q, rem_d, idx_q, idx_d;
  logic [CH_NUM-1:0][ADDR_W-1:0]    base_q, base_d;
  logic [CH_NUM-1:0]                dir_q, dir_d, pend_q, pend_d;
  logic [CH_W-1:0]                  rr_q, rr_d;
  logic [GLB_RD_LAT-1:0]            pv_q, pv_d;
  logic [GLB_RD_LAT-1:0][CH_W-1:0]  pid_q, pid_d;
  logic                             started_q, started_d;

  logic [CH_NUM-1:0]                elig_s;
  logic [CH_NUM-1:0]                active_s;
  logic                             any_s, req_s, gnt_s, ret_s;
  logic [CH_W-1:0]                  sel_s, ret_id_s;

  // Eligibility and round-robin pick of the first eligible channel at or after rr_q
  always_comb begin
    int j;
    j      = 0;
    any_s  = 1'b0;
    sel_s  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      active_s[c] = (st_q[c] == ST_ACTIVE);
      elig_s[c]   = active_s[c] && (rem_q[c] != '0) &&
                    (dir_q[c] ? !fifo_empty_i[c] : (!pend_q[c] && !fifo_full_i[c]));
    end
    for (int i = 0; i < CH_NUM; i++) begin
      j = (int'(rr_q) + i >= CH_NUM) ? int'(rr_q) + i - CH_NUM : int'(rr_q) + i;
      if (!any_s && elig_s[j]) begin
        any_s = 1'b1;
        sel_s = CH_W'(j);
      end else begin
        any_s = any_s;
      end
    end
    req_s    = any_s && !soft_clr_i;
    gnt_s    = req_s && glb_gnt_i;
    ret_s    = pv_q[GLB_RD_LAT-1] && !soft_clr_i;
    ret_id_s = pid_q[GLB_RD_LAT-1];
  end

  // GLB port, FIFO strobes and status outputs
  always_comb begin
    glb_req_o        = req_s;
    glb_we_o         = req_s && dir_q[sel_s];
    glb_addr_o       = req_s ? (base_q[sel_s] + ADDR_W'(idx_q[sel_s]) * addr_stride_i) : '0;
    glb_wdata_o      = (req_s && dir_q[sel_s]) ? fifo_pop_data_i[int'(sel_s)*DATA_W +: DATA_W] : '0;
    fifo_pop_o       = (gnt_s && dir_q[sel_s]) ? (ONE_HOT0 << sel_s) : '0;
    fifo_push_o      = ret_s ? (ONE_HOT0 << ret_id_s) : '0;
    fifo_push_data_o = ret_s ? glb_rdata_i : '0;
    for (int c = 0; c < CH_NUM; c++) begin
      ch_done_o[c] = (st_q[c] == ST_DONE) && !soft_clr_i;
    end
    all_done_o = started_q && (active_s == '0) && (pv_q == '0) && !soft_clr_i;
  end

  // Next-state for channel FSMs, counters, RR pointer and read-return pipe
  always_comb begin
    st_d      = st_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    base_d    = base_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    rr_d      = rr_q;
    pv_d      = pv_q;
    pid_d     = pid_q;
    started_d = started_q;
    if (soft_clr_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        st_d[c] = ST_IDLE;
      end
      rem_d     = '0;
      idx_d     = '0;
      base_d    = '0;
      dir_d     = '0;
      pend_d    = '0;
      rr_d      = '0;
      pv_d      = '0;
      pid_d     = '0;
      started_d = 1'b0;
    end else begin
      started_d = started_q || start_i;
      pv_d[0]   = gnt_s && !dir_q[sel_s];
      pid_d[0]  = sel_s;
      for (int k = 1; k < GLB_RD_LAT; k++) begin
        pv_d[k]  = pv_q[k-1];
        pid_d[k] = pid_q[k-1];
      end
      rr_d = gnt_s ? ((int'(sel_s) == CH_NUM - 1) ? '0 : sel_s + 1'b1) : rr_q;
      for (int c = 0; c < CH_NUM; c++) begin
        case (st_q[c])
          ST_IDLE, ST_DONE: begin
            if (start_i && ch_need_i[c]) begin
              st_d[c]   = ST_ACTIVE;
              dir_d[c]  = ch_dir_i[c];
              rem_d[c]  = ch_num_i[c*CNT_W +: CNT_W];
              idx_d[c]  = '0;
              base_d[c] = ch_base_addr_i[c*ADDR_W +: ADDR_W];
            end else begin
              st_d[c] = st_q[c];
            end
          end
          ST_ACTIVE: begin
            st_d[c] = ((rem_q[c] == '0) && !pend_q[c]) ? ST_DONE : ST_ACTIVE;
          end
          default: st_d[c] = ST_IDLE;
        endcase
        // A channel can never be both granted and returning: a read grant needs pend clear.
        if (gnt_s && (sel_s == CH_W'(c))) begin
          rem_d[c]  = rem_q[c] - 1'b1;
          idx_d[c]  = idx_q[c] + 1'b1;
          pend_d[c] = !dir_q[c];
        end else if (ret_s && (ret_id_s == CH_W'(c))) begin
          pend_d[c] = 1'b0;
        end else begin
          pend_d[c] = pend_q[c];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        st_q[c] <= ST_IDLE;
      end
      rem_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      dir_q     <= '0;
      pend_q    <= '0;
      rr_q      <= '0;
      pv_q      <= '0;
      pid_q     <= '0;
      started_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      pv_q      <= pv_d;
      pid_q     <= pid_d;
      started_q <= started_d;
    end
  end

`ifdef XFER_PERF_CNT_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d;

  // Saturating busy/stall counters, restarted by every start
  always_comb begin
    if (soft_clr_i || start_i) begin
      busy_d  = 32'd0;
      stall_d = 32'd0;
    end else begin
      busy_d  = ((active_s != '0) && (busy_q != 32'hFFFF_FFFF)) ? busy_q + 32'd1 : busy_q;
      stall_d = (req_s && !glb_gnt_i && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cyc_o  = busy_q;
  assign perf_stall_cyc_o = stall_q;
`endif

endmodule

// File: tb/tb_glb_fifo_xfer_engine.sv
// Directed bench: two 8-channel engines, one with read latency 1 and one with latency 3.
module tb_glb_fifo_xfer_engine;

  localparam int CH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr1 = 1'b0, clr3 = 1'b0, start1 = 1'b0, start3 = 1'b0;
  logic [CH-1:0]   ch_need = '0, ch_dir = '0, fifo_full = '0, fifo_empty = '1;
  logic [CH*16-1:0] ch_num = '0;
  logic [CH*32-1:0] ch_base = '0, pop_data = '0;
  logic [31:0]     stride = 32'd0;
  logic            gnt = 1'b0;
  logic [31:0]     rdata1, rdata3;
  logic [31:0]     rd1_q;
  logic [31:0]     rd3_q [3];

  logic [CH-1:0]   o1_push, o1_pop, o1_done, o3_push, o3_pop, o3_done;
  logic [31:0]     o1_pdata, o1_addr, o1_wdata, o3_pdata, o3_addr, o3_wdata;
  logic            o1_req, o1_we, o1_all, o3_req, o3_we, o3_all;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  glb_fifo_xfer_engine #(.CH_NUM(CH), .ADDR_W(32), .DATA_W(32), .CNT_W(16), .GLB_RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .soft_clr_i(clr1), .start_i(start1), .ch_need_i(ch_need),
    .ch_dir_i(ch_dir), .ch_num_i(ch_num), .ch_base_addr_i(ch_base), .addr_stride_i(stride),
    .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_pop_data_i(pop_data),
    .fifo_push_o(o1_push), .fifo_push_data_o(o1_pdata), .fifo_pop_o(o1_pop),
    .glb_req_o(o1_req), .glb_we_o(o1_we), .glb_addr_o(o1_addr), .glb_wdata_o(o1_wdata),
    .glb_gnt_i(gnt), .glb_rdata_i(rdata1), .ch_done_o(o1_done), .all_done_o(o1_all));

  glb_fifo_xfer_engine #(.CH_NUM(CH), .ADDR_W(32), .DATA_W(32), .CNT_W(16), .GLB_RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .soft_clr_i(clr3), .start_i(start3), .ch_need_i(ch_need),
    .ch_dir_i(ch_dir), .ch_num_i(ch_num), .ch_base_addr_i(ch_base), .addr_stride_i(stride),
    .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_pop_data_i(pop_data),
    .fifo_push_o(o3_push), .fifo_push_data_o(o3_pdata), .fifo_pop_o(o3_pop),
    .glb_req_o(o3_req), .glb_we_o(o3_we), .glb_addr_o(o3_addr), .glb_wdata_o(o3_wdata),
    .glb_gnt_i(gnt), .glb_rdata_i(rdata3), .ch_done_o(o3_done), .all_done_o(o3_all));

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // GLB memory model: read data is a fixed function of the address, returned after the latency
  always @(posedge clk) begin
    rd1_q    <= (o1_req && gnt && !o1_we) ? rdf(o1_addr) : 32'hDEAD_0001;
    rd3_q[0] <= (o3_req && gnt && !o3_we) ? rdf(o3_addr) : 32'hDEAD_0003;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign rdata1 = rd1_q;
  assign rdata3 = rd3_q[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic d, input logic [15:0] n, input logic [31:0] b);
    ch_dir[c]          = d;
    ch_num[c*16 +: 16] = n;
    ch_base[c*32 +: 32] = b;
  endtask

  int          w;
  int          seq [3] = '{1, 2, 5};
  int          c, pc;
  logic [31:0] exp_addr, prev_addr;
  logic [31:0] wq [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

  initial begin
    // reset
    smp;
    check("rst_req", o1_req, 0);
    check("rst_done", o1_done, 0);
    check("rst_all", o1_all, 0);
    check("rst_push_pop", {o1_push, o1_pop}, 0);
    nxt; nxt; rst_n = 1'b1;

    // single read ch0, LAT=1
    set_ch(0, 1'b0, 16'd4, 32'h100);
    stride = 32'd4; gnt = 1'b1; ch_need = 8'h01; start1 = 1'b1;
    smp; check("t1_req_idle", o1_req, 0);
    nxt; start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp;
      check("t1_req", o1_req, 1);
      check("t1_addr", o1_addr, 32'h100 + 32'(k) * 32'd4);
      check("t1_we", o1_we, 0);
      nxt;
      smp;
      check("t1_push", o1_push, 8'h01);
      check("t1_pdata", o1_pdata, rdf(32'h100 + 32'(k) * 32'd4));
      check("t1_req_pend", o1_req, 0);
      nxt;
    end
    w = 0; smp;
    while (!o1_done[0] && w < 4) begin nxt; smp; w++; end
    check("t1_done", o1_done, 8'h01);
    check("t1_all", o1_all, 1);
    nxt;

    // write ch3, FIFO holds A,B,C
    set_ch(3, 1'b1, 16'd3, 32'h200);
    ch_need = 8'h08; fifo_empty[3] = 1'b0; pop_data[3*32 +: 32] = wq[0]; start1 = 1'b1;
    smp; nxt; start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      check("t2_req_we", {o1_req, o1_we}, 2'b11);
      check("t2_addr", o1_addr, 32'h200 + 32'(k) * 32'd4);
      check("t2_wdata", o1_wdata, wq[k]);
      check("t2_pop", o1_pop, 8'h08);
      nxt;
      if (k < 2) pop_data[3*32 +: 32] = wq[k+1];
      else fifo_empty[3] = 1'b1;
    end
    smp;
    check("t2_idle_req", o1_req, 0);
    check("t2_idle_pop", o1_pop, 0);
    w = 0;
    while (!o1_done[3] && w < 4) begin nxt; smp; w++; end
    check("t2_done", o1_done, 8'h09);
    nxt;

    // soft clear
    clr1 = 1'b1;
    smp; check("clr_outs", {o1_req, o1_done, o1_all}, 0);
    nxt; clr1 = 1'b0;
    smp; check("clr_after", {o1_done, o1_all}, 0);
    nxt;

    // round robin: reads ch1,ch2, write ch5
    set_ch(1, 1'b0, 16'd3, 32'h1000);
    set_ch(2, 1'b0, 16'd3, 32'h2000);
    set_ch(5, 1'b1, 16'd3, 32'h5000);
    stride = 32'h10; ch_need = 8'h26; fifo_empty[5] = 1'b0; pop_data[5*32 +: 32] = 32'h5555_0005;
    start1 = 1'b1;
    smp; nxt; start1 = 1'b0;
    prev_addr = 32'd0;
    for (int k = 0; k < 9; k++) begin
      smp;
      c = seq[k % 3];
      exp_addr = 32'(c) * 32'h1000 + 32'(k / 3) * 32'h10;
      check("t3_req", o1_req, 1);
      check("t3_addr", o1_addr, exp_addr);
      check("t3_we", o1_we, (c == 5) ? 1 : 0);
      check("t3_pop", o1_pop, (c == 5) ? 8'h20 : 8'h00);
      pc = (k > 0) ? seq[(k - 1) % 3] : 5;
      check("t3_push", o1_push, (pc != 5) ? (8'h01 << pc) : 8'h00);
      if (pc != 5) check("t3_pdata", o1_pdata, rdf(prev_addr));
      prev_addr = exp_addr;
      nxt;
    end
    fifo_empty[5] = 1'b1;
    w = 0; smp;
    while (!o1_all && w < 4) begin nxt; smp; w++; end
    check("t3_all", o1_all, 1);
    check("t3_done", o1_done, 8'h26);
    nxt;

    // backpressure then FIFO full on ch0
    set_ch(0, 1'b0, 16'd2, 32'h300);
    stride = 32'd8; ch_need = 8'h01; gnt = 1'b0; start1 = 1'b1;
    smp; nxt; start1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp;
      check("t4_bp_req", o1_req, 1);
      check("t4_bp_addr", o1_addr, 32'h300);
      check("t4_bp_strobes", {o1_push, o1_pop}, 0);
      nxt;
    end
    gnt = 1'b1;
    smp; check("t4_addr0", o1_addr, 32'h300);
    nxt; fifo_full[0] = 1'b1;
    smp;
    check("t4_push0", o1_push, 8'h01);
    check("t4_pdata0", o1_pdata, rdf(32'h300));
    nxt;
    for (int k = 0; k < 3; k++) begin
      smp; check("t4_full_req", o1_req, 0); nxt;
    end
    fifo_full[0] = 1'b0;
    smp;
    check("t4_req1", o1_req, 1);
    check("t4_addr1", o1_addr, 32'h308);
    nxt;
    smp; check("t4_push1", o1_push, 8'h01);
    nxt;

    // num=0 start on ch7
    set_ch(7, 1'b0, 16'd0, 32'h700);
    ch_need = 8'h80; start1 = 1'b1;
    smp; nxt; start1 = 1'b0;
    w = 0; smp; check("t5_req", o1_req, 0);
    while (!o1_done[7] && w < 3) begin nxt; smp; check("t5_req", o1_req, 0); w++; end
    check("t5_done7", o1_done[7], 1);
    nxt;

    // LAT=3: soft clear with two reads in flight
    set_ch(0, 1'b0, 16'd2, 32'h10);
    set_ch(1, 1'b0, 16'd2, 32'h20);
    stride = 32'd4; ch_need = 8'h03; start3 = 1'b1;
    smp; nxt; start3 = 1'b0;
    smp; check("t6_req0", {o3_req, o3_addr}, {1'b1, 32'h10}); nxt;
    smp; check("t6_req1", {o3_req, o3_addr}, {1'b1, 32'h20}); nxt;
    clr3 = 1'b1;
    smp; check("t6_clr_outs", {o3_req, o3_push, o3_done, o3_all}, 0);
    nxt; clr3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp;
      check("t6_no_push", o3_push, 0);
      check("t6_no_req", {o3_req, o3_all}, 0);
      nxt;
    end
    set_ch(2, 1'b0, 16'd1, 32'h40);
    ch_need = 8'h04; start3 = 1'b1;
    smp; nxt; start3 = 1'b0;
    smp; check("t6_new_req", {o3_req, o3_addr}, {1'b1, 32'h40}); nxt;
    smp; check("t6_lat_a", o3_push, 0); nxt;
    smp; check("t6_lat_b", o3_push, 0); nxt;
    smp;
    check("t6_push", o3_push, 8'h04);
    check("t6_pdata", o3_pdata, rdf(32'h40));
    nxt;
    w = 0; smp;
    while (!o3_all && w < 4) begin nxt; smp; w++; end
    check("t6_all", o3_all, 1);
    check("t6_done", o3_done, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
